// File: rtl/bnn_layer_ctrl.sv
// Binary-weight neural network layer sequencer.
// Buffers one input vector, then evaluates each neuron by +/- accumulation.
module bnn_layer_ctrl #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 16,
  parameter int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_data,
  output logic                  w_rd_en,
  output logic [IW-1:0]         w_addr,
  input  logic [NUM_INPUTS-1:0] w_rdata,
  input  logic [63:0]           b_rdata,
  input  logic                  act_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_data,
  output logic [IW-1:0]         out_idx
);

  localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NUM_INPUTS - 1);
  localparam logic [IW-1:0] N_LAST = IW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    LATCH,
    ACC,
    EMIT,
    DONE
  } state_t;

  state_t                state;
  logic [63:0]           xbuf [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] w_q;
  logic                  act_q;
  logic [63:0]           acc;
  logic [63:0]           acc_next;
  logic [63:0]           x_sel;
  logic [CW-1:0]         k;
  logic [IW-1:0]         n;

  // Next accumulator value: add input k when its weight bit is 1, else subtract.
  always_comb begin
    x_sel    = xbuf[k];
    acc_next = w_q[k] ? (acc + x_sel) : (acc - x_sel);
  end

  // Input vector buffer; only written while loading, kept across neurons.
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && in_valid) begin
      xbuf[k] <= in_data;
    end
  end

  // Layer sequencer with registered handshake and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      k         <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            k        <= '0;
            n        <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (k == K_LAST) begin
              state    <= FETCH;
              k        <= '0;
              in_ready <= 1'b0;
              w_rd_en  <= 1'b1;
              w_addr   <= n;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        FETCH: begin
          state   <= LATCH;
          w_rd_en <= 1'b0;
        end
        LATCH: begin
          state <= ACC;
          w_q   <= w_rdata;
          act_q <= act_rdata;
          acc   <= b_rdata;
          k     <= '0;
        end
        ACC: begin
          acc <= acc_next;
          if (k == K_LAST) begin
            state     <= EMIT;
            k         <= '0;
            out_valid <= 1'b1;
            out_idx   <= n;
            out_data  <= act_q ? acc_next : '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            if (n == N_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              n       <= n + 1'b1;
              w_rd_en <= 1'b1;
              w_addr  <= n + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
